// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - sequential AES-128/192/256 key schedule, one word per handshake
//
// Purpose:
//   Expands a 128/192/256-bit cipher key into 44/52/60 round-key words.
//   Each word is offered on a valid/ready stream. The round constant is
//   produced by GF(2^8) doubling, so there is no rcon table. SubWord is
//   done by an external combinational S-box shared with the cipher.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start            begin an expansion (sampled only while idle)
//   key_size[1:0]    0=128, 1=192, 2=256, 3 behaves as 0
//   key_in[255:0]    cipher key, word 0 in key_in[255:224]
//   busy             expansion in progress
//   sub_in/sub_out   word to substitute / its S-box image (same cycle)
//   w_valid/w_ready  expanded-key word handshake
//   w_index, w_data  index i and value of w[i]
//   done             one-cycle pulse after the final word is accepted

module aes_key_expander #(
  parameter int WORD   = 32,
  parameter int MAX_NK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      key_size,
  input  logic [255:0]    key_in,
  output logic            busy,
  output logic [WORD-1:0] sub_in,
  input  logic [WORD-1:0] sub_out,
  output logic            w_valid,
  input  logic            w_ready,
  output logic [5:0]      w_index,
  output logic [WORD-1:0] w_data,
  output logic            done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Window holds w[n-Nk .. n-1] left-aligned, where n is the next word to
  // be computed; win[0] is always w[n-Nk] and win[nk_m1] is w[n-1].
  logic [WORD-1:0] win [MAX_NK];
  logic [2:0]      nk_m1;      // Nk-1 for the latched key size
  logic [5:0]      last_idx;   // N-1 for the latched key size
  logic [2:0]      phase;      // w_index mod Nk
  logic [7:0]      rcon;
  logic            done_q;

  logic [2:0]      nk_m1_d;
  logic [5:0]      last_idx_d;
  logic            start_ok;
  logic            accept;
  logic            final_accept;
  logic            key_phase;
  logic            rot_mode;
  logic            sub_mode;
  logic [WORD-1:0] last_word;
  logic [WORD-1:0] temp;
  logic [WORD-1:0] new_word;
  logic [2:0]      phase_next;

  assign busy    = (state_q == S_RUN);
  assign w_valid = (state_q == S_RUN);
  assign done    = done_q;
  assign accept  = (state_q == S_RUN) && w_ready;

  // Key size decode; code 3 falls back to AES-128.
  always_comb begin
    nk_m1_d    = 3'd3;
    last_idx_d = 6'd43;
    case (key_size)
      2'd1: begin
        nk_m1_d    = 3'd5;
        last_idx_d = 6'd51;
      end
      2'd2: begin
        nk_m1_d    = 3'd7;
        last_idx_d = 6'd59;
      end
      default: begin
        nk_m1_d    = 3'd3;
        last_idx_d = 6'd43;
      end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state and handshake decode
  always_comb begin
    state_d      = state_q;
    start_ok     = 1'b0;
    final_accept = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          start_ok = 1'b1;
        end
      end
      S_RUN: begin
        if (accept && (w_index == last_idx)) begin
          state_d      = S_IDLE;
          final_accept = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The word after w_index is still a raw key word while w_index+1 < Nk.
  assign key_phase  = (w_index < {3'b000, nk_m1});
  assign phase_next = (phase == nk_m1) ? 3'd0 : phase + 3'd1;

  // Next word index i = w_index+1; i mod Nk == 0 exactly when phase == Nk-1,
  // and i mod 8 == 4 when phase == 3 for AES-256.
  assign rot_mode  = (phase == nk_m1);
  assign sub_mode  = (nk_m1 == 3'd7) && (phase == 3'd3);
  assign last_word = win[nk_m1];

  // Only registered state feeds sub_in, so there is no path from w_ready.
  assign sub_in = rot_mode ? {last_word[WORD-9:0], last_word[WORD-1:WORD-8]}
                           : last_word;

  always_comb begin
    temp = last_word;
    if (rot_mode) begin
      temp = sub_out ^ {rcon, {(WORD-8){1'b0}}};
    end else if (sub_mode) begin
      temp = sub_out;
    end
  end

  assign new_word = win[0] ^ temp;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_NK; k++) begin
        win[k] <= '0;
      end
      nk_m1    <= 3'd3;
      last_idx <= 6'd43;
      phase    <= 3'd0;
      rcon     <= 8'h01;
      w_index  <= 6'd0;
      w_data   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= final_accept;
      if (start_ok) begin
        for (int k = 0; k < MAX_NK; k++) begin
          win[k] <= key_in[255 - WORD*k -: WORD];
        end
        nk_m1    <= nk_m1_d;
        last_idx <= last_idx_d;
        phase    <= 3'd0;
        rcon     <= 8'h01;
        w_index  <= 6'd0;
        w_data   <= key_in[255 -: WORD];
      end else if (accept && !final_accept) begin
        w_index <= w_index + 6'd1;
        phase   <= phase_next;
        if (key_phase) begin
          // Still streaming the key itself; phase equals w_index here.
          w_data <= win[phase + 3'd1];
        end else begin
          w_data <= new_word;
          for (int k = 0; k < MAX_NK - 1; k++) begin
            if (3'(k) < nk_m1) begin
              win[k] <= win[k + 1];
            end
          end
          win[nk_m1] <= new_word;
          if (rot_mode) begin
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
          end
        end
      end
    end
  end

endmodule
